// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the SDRAM arbiter slice.
// - Arbiter FSM state encoding.
// - Requester port identifiers.
// - Bus width constants that match the embedded SDRAM controller.
package sdram_arbiter_pkg;

    localparam int ADDR_WIDTH = 23;
    localparam int DATA_WIDTH = 32;
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int NUM_PORTS  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [1:0] port_id_t;

    localparam port_id_t PORT_VIDEO = 2'd0;
    localparam port_id_t PORT_A     = 2'd1;
    localparam port_id_t PORT_B     = 2'd2;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester and SDRAM-controller signal bundle for the arbiter.
// - slave modport: the arbiter's view. It takes requests and completion
//   pulses, and it drives acks, read data and the ram command/hold outputs.
// - master modport: the environment's view (requesters plus ram).
// Port 0 is read-only video fetch. Ports 1 and 2 are read/write.
interface sdram_arbiter_if #(
    parameter int ADDR_WIDTH = sdram_arbiter_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sdram_arbiter_pkg::DATA_WIDTH
);
    localparam int MASK_BITS = DATA_WIDTH / 8;

    logic                  p0_req;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic                  p0_ack;
    logic [DATA_WIDTH-1:0] p0_rdata;

    logic                  p1_req;
    logic                  p1_we;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [MASK_BITS-1:0]  p1_mask;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_ack;
    logic [DATA_WIDTH-1:0] p1_rdata;

    logic                  p2_req;
    logic                  p2_we;
    logic [ADDR_WIDTH-1:0] p2_addr;
    logic [MASK_BITS-1:0]  p2_mask;
    logic [DATA_WIDTH-1:0] p2_wdata;
    logic                  p2_ack;
    logic [DATA_WIDTH-1:0] p2_rdata;

    logic                  ram_rd_request;
    logic [ADDR_WIDTH-1:0] ram_rd_address;
    logic                  ram_rd_available;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic                  ram_wr_request;
    logic                  ram_wr_done;
    logic [MASK_BITS-1:0]  ram_wr_mask;
    logic [ADDR_WIDTH-1:0] ram_wr_address;
    logic [DATA_WIDTH-1:0] ram_wr_data;

    logic                  busy;

    modport slave (
        input  p0_req, p0_addr,
        output p0_ack, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_mask, p1_wdata,
        output p1_ack, p1_rdata,
        input  p2_req, p2_we, p2_addr, p2_mask, p2_wdata,
        output p2_ack, p2_rdata,
        output ram_rd_request, ram_rd_address,
        input  ram_rd_available, ram_rd_data,
        output ram_wr_request, ram_wr_mask, ram_wr_address, ram_wr_data,
        input  ram_wr_done,
        output busy
    );

    modport master (
        output p0_req, p0_addr,
        input  p0_ack, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_mask, p1_wdata,
        input  p1_ack, p1_rdata,
        output p2_req, p2_we, p2_addr, p2_mask, p2_wdata,
        input  p2_ack, p2_rdata,
        input  ram_rd_request, ram_rd_address,
        output ram_rd_available, ram_rd_data,
        input  ram_wr_request, ram_wr_mask, ram_wr_address, ram_wr_data,
        output ram_wr_done,
        input  busy
    );

endinterface

// File: rtl/sdram_arb_pick.sv
// Combinational grant selection.
// Inputs:
// - reqs: request levels, bit i = port i.
// - rr_last: last port-1/2 winner.
// - p0_count: consecutive video grants so far.
// Outputs:
// - grant_valid: some port wins this cycle.
// - grant_id: the winning port.
// Video wins unless it has used up its consecutive-grant allowance while a
// general port waits. Ports 1/2 alternate on a tie.
module sdram_arb_pick
    import sdram_arbiter_pkg::*;
#(
    parameter int P0_MAX_CONSECUTIVE = 4
) (
    input  logic [2:0] reqs,
    input  port_id_t   rr_last,
    input  logic [3:0] p0_count,
    output logic       grant_valid,
    output port_id_t   grant_id
);
    localparam logic [3:0] P0_MAX = 4'(P0_MAX_CONSECUTIVE);

    logic p0_ok;

    assign p0_ok = reqs[0] && ((p0_count < P0_MAX) || !(reqs[1] || reqs[2]));

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = PORT_VIDEO;
        if (p0_ok) begin
            grant_valid = 1'b1;
            grant_id    = PORT_VIDEO;
        end else if (reqs[1] && reqs[2]) begin
            grant_valid = 1'b1;
            grant_id    = (rr_last == PORT_A) ? PORT_B : PORT_A;
        end else if (reqs[1]) begin
            grant_valid = 1'b1;
            grant_id    = PORT_A;
        end else if (reqs[2]) begin
            grant_valid = 1'b1;
            grant_id    = PORT_B;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Three-port arbiter in front of the embedded SDRAM controller.
// Ports:
// - clk: system clock.
// - rst: synchronous active-high reset. The ram reset is its inverse,
//   driven outside this block.
// - bus: sdram_arbiter_if.slave. Carries the video read port, two
//   read/write ports, the ram command/hold outputs, the completion pulses
//   and busy.
// One transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> DONE.
// The granted command is latched at grant and held on the ram_* outputs
// until the ram completes it.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH         = sdram_arbiter_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH         = sdram_arbiter_pkg::DATA_WIDTH,
    parameter int P0_MAX_CONSECUTIVE = 4
) (
    input logic         clk,
    input logic         rst,
    sdram_arbiter_if.slave bus
);
    localparam int         MASK_BITS = DATA_WIDTH / 8;
    localparam logic [3:0] P0_MAX    = 4'(P0_MAX_CONSECUTIVE);

    state_t                state_reg, state_next;
    port_id_t              grant_id_reg, rr_last_reg;
    logic                  op_we_reg;
    logic [3:0]            p0_count_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [MASK_BITS-1:0]  mask_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;

    logic                  grant_valid;
    port_id_t              grant_id;
    logic                  complete;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [MASK_BITS-1:0]  sel_mask;
    logic [DATA_WIDTH-1:0] sel_wdata;

    sdram_arb_pick #(
        .P0_MAX_CONSECUTIVE(P0_MAX_CONSECUTIVE)
    ) u_pick (
        .reqs       ({bus.p2_req, bus.p1_req, bus.p0_req}),
        .rr_last    (rr_last_reg),
        .p0_count   (p0_count_reg),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    // Only the pulse that matches the latched op ends WAIT. The other
    // pulse is ignored, even when both arrive in the same cycle.
    assign complete = (state_reg == WAIT) &&
                      (op_we_reg ? bus.ram_wr_done : bus.ram_rd_available);

    // Command fields of the winning port. Video is always a plain read.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = bus.p0_addr;
        sel_mask  = '0;
        sel_wdata = '0;
        case (grant_id)
            PORT_A: begin
                sel_we    = bus.p1_we;
                sel_addr  = bus.p1_addr;
                sel_mask  = bus.p1_mask;
                sel_wdata = bus.p1_wdata;
            end
            PORT_B: begin
                sel_we    = bus.p2_we;
                sel_addr  = bus.p2_addr;
                sel_mask  = bus.p2_mask;
                sel_wdata = bus.p2_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (complete) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_id_reg <= PORT_VIDEO;
            rr_last_reg  <= PORT_B;
            op_we_reg    <= 1'b0;
            p0_count_reg <= 4'd0;
            addr_reg     <= '0;
            mask_reg     <= '0;
            wdata_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE) begin
                if (!bus.p0_req) begin
                    p0_count_reg <= 4'd0;
                end
                if (grant_valid) begin
                    grant_id_reg <= grant_id;
                    op_we_reg    <= sel_we;
                    addr_reg     <= sel_addr;
                    mask_reg     <= sel_mask;
                    wdata_reg    <= sel_wdata;
                    if (grant_id == PORT_VIDEO) begin
                        if (p0_count_reg < P0_MAX) begin
                            p0_count_reg <= p0_count_reg + 4'd1;
                        end
                    end else begin
                        p0_count_reg <= 4'd0;
                        rr_last_reg  <= grant_id;
                    end
                end
            end
        end
    end

    // Per-port ack and read-data registers. An ack is high only in DONE,
    // one cycle after the completion pulse. Read data persists until
    // that port's next read completes.
    logic [NUM_PORTS-1:0]  ack_vec;
    logic [DATA_WIDTH-1:0] rdata_vec [NUM_PORTS];

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : gen_port
            logic                  ack_reg;
            logic [DATA_WIDTH-1:0] rdata_reg;
            logic                  mine;

            assign mine = complete && (grant_id_reg == port_id_t'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    ack_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    ack_reg <= mine;
                    if (mine && !op_we_reg) begin
                        rdata_reg <= bus.ram_rd_data;
                    end
                end
            end

            assign ack_vec[gi]   = ack_reg;
            assign rdata_vec[gi] = rdata_reg;
        end
    endgenerate

    assign bus.p0_ack   = ack_vec[0];
    assign bus.p1_ack   = ack_vec[1];
    assign bus.p2_ack   = ack_vec[2];
    assign bus.p0_rdata = rdata_vec[0];
    assign bus.p1_rdata = rdata_vec[1];
    assign bus.p2_rdata = rdata_vec[2];

    assign bus.ram_rd_request = (state_reg == ISSUE) && !op_we_reg;
    assign bus.ram_wr_request = (state_reg == ISSUE) && op_we_reg;
    assign bus.ram_rd_address = addr_reg;
    assign bus.ram_wr_address = addr_reg;
    assign bus.ram_wr_mask    = mask_reg;
    assign bus.ram_wr_data    = wdata_reg;
    assign bus.busy           = (state_reg != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

    typedef struct {
        int          port;
        logic [31:0] data;
        bit          chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    int   ack_cyc_q[$];
    int   ack_cnt [3] = '{0, 0, 0};

    // ram model state
    logic [31:0] mem [256];
    int          ram_lat = 2;
    int          cnt = 0;
    bit          pend_we = 1'b0;
    logic [22:0] lat_addr = '0;
    logic [31:0] lat_data = '0;
    logic [3:0]  lat_mask = '0;
    int          wr_pulses = 0;
    int          rd_pulses = 0;
    int          hold_err = 0;
    int          done_cyc = -1;
    logic        model_rd_avail = 1'b0;
    logic        inject_rd = 1'b0;

    sdram_arbiter_if bus ();

    sdram_arbiter #(
        .ADDR_WIDTH(23),
        .DATA_WIDTH(32),
        .P0_MAX_CONSECUTIVE(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.ram_rd_available = model_rd_avail | inject_rd;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(int p);
        case (p)
            0:       return bus.p0_ack;
            1:       return bus.p1_ack;
            default: return bus.p2_ack;
        endcase
    endfunction

    function automatic logic [31:0] rdata_of(int p);
        case (p)
            0:       return bus.p0_rdata;
            1:       return bus.p1_rdata;
            default: return bus.p2_rdata;
        endcase
    endfunction

    // ram model: completes each command ram_lat cycles after its request
    // and watches that the held command does not move meanwhile.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        bus.ram_wr_done = 1'b0;
        bus.ram_rd_data = 32'h0;
        forever begin
            @(negedge clk);
            model_rd_avail  = 1'b0;
            bus.ram_wr_done = 1'b0;
            if (rst) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    if (pend_we && (bus.ram_wr_data !== lat_data ||
                        bus.ram_wr_address !== lat_addr || bus.ram_wr_mask !== lat_mask))
                        hold_err++;
                    if (!pend_we && bus.ram_rd_address !== lat_addr)
                        hold_err++;
                    cnt--;
                    if (cnt == 0) begin
                        if (pend_we) begin
                            for (int b = 0; b < 4; b++)
                                if (lat_mask[b]) mem[lat_addr[7:0]][8*b +: 8] = lat_data[8*b +: 8];
                            bus.ram_wr_done = 1'b1;
                            done_cyc = cyc;
                        end else begin
                            bus.ram_rd_data = mem[lat_addr[7:0]];
                            model_rd_avail  = 1'b1;
                        end
                    end
                end
                if (bus.ram_wr_request) begin
                    pend_we  = 1'b1;
                    lat_addr = bus.ram_wr_address;
                    lat_data = bus.ram_wr_data;
                    lat_mask = bus.ram_wr_mask;
                    cnt      = ram_lat;
                    wr_pulses++;
                end else if (bus.ram_rd_request) begin
                    pend_we  = 1'b0;
                    lat_addr = bus.ram_rd_address;
                    cnt      = ram_lat;
                    rd_pulses++;
                end
            end
        end
    end

    // Ack monitor: pops the scoreboard in order of acks.
    initial begin
        logic [2:0] acks;
        exp_t e;
        forever begin
            @(negedge clk);
            acks = {bus.p2_ack, bus.p1_ack, bus.p0_ack};
            if (acks != 3'b000) begin
                check("ack_onehot", 64'($countones(acks)), 64'd1);
                for (int p = 0; p < 3; p++) begin
                    if (acks[p]) begin
                        ack_cnt[p]++;
                        ack_cyc_q.push_back(cyc);
                        check("ack_expected", 64'(sb.size() > 0), 64'd1);
                        if (sb.size() > 0) begin
                            e = sb.pop_front();
                            check("ack_port", 64'(p), 64'(e.port));
                            if (e.chk) check("rdata", 64'(rdata_of(p)), 64'(e.data));
                            $display("txn: port %0d ack at cycle %0d rdata %08h", p, cyc, rdata_of(p));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_cmd(int p, bit we, logic [22:0] a, logic [3:0] m, logic [31:0] d);
        case (p)
            0: begin bus.p0_addr = a; bus.p0_req = 1'b1; end
            1: begin bus.p1_we = we; bus.p1_addr = a; bus.p1_mask = m; bus.p1_wdata = d; bus.p1_req = 1'b1; end
            default: begin bus.p2_we = we; bus.p2_addr = a; bus.p2_mask = m; bus.p2_wdata = d; bus.p2_req = 1'b1; end
        endcase
    endtask

    task automatic release_req(int p);
        case (p)
            0:       bus.p0_req = 1'b0;
            1:       bus.p1_req = 1'b0;
            default: bus.p2_req = 1'b0;
        endcase
    endtask

    task automatic run_txn(int p, bit we, logic [22:0] a, logic [3:0] m, logic [31:0] d,
                           logic [31:0] exp_data, bit chk);
        bit got;
        sb.push_back('{p, exp_data, chk});
        @(negedge clk);
        drive_cmd(p, we, a, m, d);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (ack_of(p)) got = 1'b1;
        end
        release_req(p);
        check("txn_ack_seen", 64'(got), 64'd1);
    endtask

    task automatic drain(int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_busy"},     64'(bus.busy), 64'd0);
        check({tag, "_rd_req"},   64'(bus.ram_rd_request), 64'd0);
        check({tag, "_wr_req"},   64'(bus.ram_wr_request), 64'd0);
        check({tag, "_rd_addr"},  64'(bus.ram_rd_address), 64'd0);
        check({tag, "_wr_addr"},  64'(bus.ram_wr_address), 64'd0);
        check({tag, "_wr_mask"},  64'(bus.ram_wr_mask), 64'd0);
        check({tag, "_wr_data"},  64'(bus.ram_wr_data), 64'd0);
        check({tag, "_acks"},     64'({bus.p2_ack, bus.p1_ack, bus.p0_ack}), 64'd0);
        check({tag, "_p0_rdata"}, 64'(bus.p0_rdata), 64'd0);
        check({tag, "_p1_rdata"}, 64'(bus.p1_rdata), 64'd0);
        check({tag, "_p2_rdata"}, 64'(bus.p2_rdata), 64'd0);
    endtask

    initial begin
        int w0, r0, a1, gap;
        bit seen;
        bus.p0_req = 1'b0; bus.p0_addr = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_mask = '0; bus.p1_wdata = '0;
        bus.p2_req = 1'b0; bus.p2_we = 1'b0; bus.p2_addr = '0; bus.p2_mask = '0; bus.p2_wdata = '0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // p1 write then p2 read of the same word
        ram_lat = 2;
        w0 = wr_pulses;
        run_txn(1, 1'b1, 23'h000123, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
        check("t1_wr_pulses", 64'(wr_pulses - w0), 64'd1);
        check("t1_p1_acks", 64'(ack_cnt[1]), 64'd1);
        run_txn(2, 1'b0, 23'h000123, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);

        // Byte-masked write
        run_txn(1, 1'b1, 23'h000010, 4'hF, 32'h11223344, 32'h0, 1'b0);
        run_txn(1, 1'b1, 23'h000010, 4'b0001, 32'hAABBCCDD, 32'h0, 1'b0);
        run_txn(1, 1'b0, 23'h000010, 4'h0, 32'h0, 32'h112233DD, 1'b1);

        // A p2 grant leaves rr_last at port 2 before the three-way contention.
        run_txn(2, 1'b0, 23'h000010, 4'h0, 32'h0, 32'h112233DD, 1'b1);

        // All three hold req: video starvation bound of 4
        ram_lat = 1;
        begin
            int order [15] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1};
            for (int i = 0; i < 15; i++)
                sb.push_back('{order[i], (order[i] == 1) ? 32'h112233DD : 32'hDEADBEEF, 1'b1});
        end
        @(negedge clk);
        drive_cmd(0, 1'b0, 23'h000123, 4'h0, 32'h0);
        drive_cmd(1, 1'b0, 23'h000010, 4'h0, 32'h0);
        drive_cmd(2, 1'b0, 23'h000123, 4'h0, 32'h0);
        drain(600);
        release_req(0); release_req(1); release_req(2);

        // Only p1 and p2: alternate starting with p1
        run_txn(2, 1'b0, 23'h000123, 4'h0, 32'h0, 32'hDEADBEEF, 1'b1);
        for (int i = 0; i < 4; i++)
            sb.push_back('{(i % 2 == 0) ? 1 : 2, (i % 2 == 0) ? 32'h112233DD : 32'hDEADBEEF, 1'b1});
        @(negedge clk);
        drive_cmd(1, 1'b0, 23'h000010, 4'h0, 32'h0);
        drive_cmd(2, 1'b0, 23'h000123, 4'h0, 32'h0);
        drain(300);
        release_req(1); release_req(2);

        // Only p0: back-to-back with ram latency + 3 spacing
        ram_lat = 3;
        repeat (2) @(negedge clk);
        ack_cyc_q.delete();
        for (int i = 0; i < 4; i++) sb.push_back('{0, 32'hDEADBEEF, 1'b1});
        @(negedge clk);
        drive_cmd(0, 1'b0, 23'h000123, 4'h0, 32'h0);
        drain(300);
        release_req(0);
        check("p0_ack_count", 64'(ack_cyc_q.size()), 64'd4);
        for (int i = 1; i < 4 && i < ack_cyc_q.size(); i++) begin
            gap = ack_cyc_q[i] - ack_cyc_q[i-1];
            check("p0_ack_spacing", 64'(gap), 64'(ram_lat + 3));
        end

        // Reset during WAIT of a p1 read: abandoned, no ack
        ram_lat = 8;
        repeat (2) @(negedge clk);
        r0 = rd_pulses;
        @(negedge clk);
        drive_cmd(1, 1'b0, 23'h000010, 4'h0, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (rd_pulses != r0) seen = 1'b1;
        end
        check("t5_rd_issued", 64'(seen), 64'd1);
        repeat (2) @(negedge clk);
        a1 = ack_cnt[1];
        rst = 1'b1;
        release_req(1);
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("t5_no_ack", 64'(ack_cnt[1] - a1), 64'd0);
        ram_lat = 2;
        run_txn(1, 1'b1, 23'h000040, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0);
        run_txn(1, 1'b0, 23'h000040, 4'h0, 32'h0, 32'hCAFEF00D, 1'b1);

        // Stray ram_rd_available during a p2 write WAIT is ignored
        ram_lat = 5;
        w0 = wr_pulses;
        a1 = hold_err;
        sb.push_back('{2, 32'h0, 1'b0});
        @(negedge clk);
        drive_cmd(2, 1'b1, 23'h000020, 4'hF, 32'h5A5AA5A5);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (wr_pulses != w0) seen = 1'b1;
        end
        check("t6_wr_issued", 64'(seen), 64'd1);
        @(negedge clk);
        inject_rd = 1'b1;
        @(negedge clk);
        inject_rd = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.p2_ack) seen = 1'b1;
        end
        release_req(2);
        check("t6_ack_seen", 64'(seen), 64'd1);
        #1;
        check("t6_ack_after_done", 64'(ack_cyc_q[ack_cyc_q.size()-1]), 64'(done_cyc + 1));
        check("t6_hold_stable", 64'(hold_err - a1), 64'd0);
        drain(20);
        ram_lat = 2;
        run_txn(1, 1'b0, 23'h000020, 4'h0, 32'h0, 32'h5A5AA5A5, 1'b1);

        repeat (3) @(negedge clk);
        check("total_hold_stable", 64'(hold_err), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
